// File: rtl/inst_sram_axi_bridge_if.sv
// Bus bundles for the instruction SRAM-to-AXI read bridge.
// inst_sram_if: SRAM-like request/response port; the fetch stage is the master.
// axi_rd_if   : AXI read address and read data channels; the bridge is the master.

interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch bridge: turns SRAM-like read requests into single-beat
// AXI reads and returns data in acceptance order. Writes are never accepted.

module inst_sram_axi_bridge #(
    parameter logic [3:0] ARID  = 4'd0,
    parameter int         DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    inst_sram_if.slave   sram,
    axi_rd_if.master     axi
);
    localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   araddr_q;
    logic [2:0]    arsize_q;
    logic [31:0]   rdata_q;
    logic          data_ok_q;

    logic accept;
    logic r_hs;
    logic r_done;

    // AXI keeps reads in order for a single ID, so a count is all the
    // tracking needed; beats are popped straight to the output register.
    assign accept = sram.inst_sram_req & ~sram.inst_sram_wr &
                    (state_q == AR_IDLE) & (cnt_q < CW'(DEPTH));
    assign r_hs   = axi.rvalid & axi.rready;
    assign r_done = r_hs & axi.rlast;

    assign sram.inst_sram_addr_ok = accept;
    assign sram.inst_sram_data_ok = data_ok_q;
    assign sram.inst_sram_rdata   = rdata_q;

    assign axi.arid    = ARID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = (state_q == AR_SEND);
    // Fetch always takes data_ok, so R is never stalled while reads are pending.
    assign axi.rready  = (cnt_q != '0);

    // Response ID/status and write payload carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{sram.inst_sram_wstrb, sram.inst_sram_wdata, axi.rid, axi.rresp};

    // AR channel: one address beat per accepted request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_IDLE: if (accept)                   state_d = AR_SEND;
            AR_SEND: if (axi.arvalid & axi.arready) state_d = AR_IDLE;
            default:                               state_d = AR_IDLE;
        endcase
    end

    // Outstanding reads: accept increments, last beat decrements, both hold.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !r_done)      cnt_d = cnt_q + CW'(1);
        else if (!accept && r_done) cnt_d = cnt_q - CW'(1);
    end

    // State, AR payload capture and the one-cycle response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= AR_IDLE;
            cnt_q     <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_ok_q <= r_hs;
            if (accept) begin
                araddr_q <= sram.inst_sram_addr;
                arsize_q <= {1'b0, sram.inst_sram_size};
            end
            if (r_hs) rdata_q <= axi.rdata;
        end
    end
endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Bench for inst_sram_axi_bridge: a cycle model predicts the handshakes,
// R beats push expected data into a queue popped when data_ok appears.

module tb_inst_sram_axi_bridge;
    logic clk = 1'b0;
    logic reset;

    inst_sram_if sram_if ();
    axi_rd_if    axi_if ();

    inst_sram_axi_bridge #(.ARID(4'd0), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sram  (sram_if),
        .axi   (axi_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_send = 1'b0;
    int          m_out  = 0;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_size = '0;
    logic [31:0] m_last = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic wr, input logic [31:0] addr,
                         input logic arready, input logic rvalid, input logic [31:0] rdata);
        sram_if.inst_sram_req   = req;
        sram_if.inst_sram_wr    = wr;
        sram_if.inst_sram_size  = 2'd2;
        sram_if.inst_sram_addr  = addr;
        axi_if.arready          = arready;
        axi_if.rvalid           = rvalid;
        axi_if.rdata            = rdata;
        axi_if.rlast            = 1'b1;
    endtask

    // One clock: check combinational outputs against the model, advance the
    // model, cross the edge, then check the registered response.
    task automatic step();
        logic aok, rr, beat, n_send;
        #1;
        beat   = 1'b0;
        n_send = 1'b0;
        if (!reset) begin
            aok = sram_if.inst_sram_req && !sram_if.inst_sram_wr && !m_send && (m_out < 2);
            rr  = (m_out != 0);
            chk("addr_ok", sram_if.inst_sram_addr_ok, aok);
            chk("arvalid", axi_if.arvalid, m_send);
            chk("rready",  axi_if.rready, rr);
            if (m_send) begin
                chk("araddr",  axi_if.araddr, m_addr);
                chk("arsize",  axi_if.arsize, {1'b0, m_size});
                chk("arconst", {axi_if.arid, axi_if.arlen, axi_if.arburst, axi_if.arlock,
                                axi_if.arcache, axi_if.arprot}, {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            end
            beat = axi_if.rvalid && rr;
            if (beat) exp_q.push_back(axi_if.rdata);
            n_send = m_send ? !axi_if.arready : aok;
            if (aok) begin
                m_addr = sram_if.inst_sram_addr;
                m_size = sram_if.inst_sram_size;
            end
            m_out = m_out + (aok ? 1 : 0) - ((beat && axi_if.rlast) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_send = 1'b0;
            m_out  = 0;
            m_last = '0;
            exp_q.delete();
            chk("rst_data_ok", sram_if.inst_sram_data_ok, 1'b0);
            chk("rst_rdata",   sram_if.inst_sram_rdata, 32'd0);
        end else begin
            m_send = n_send;
            if (exp_q.size() > 0) begin
                m_last = exp_q.pop_front();
                chk("data_ok", sram_if.inst_sram_data_ok, 1'b1);
                chk("rdata",   sram_if.inst_sram_rdata, m_last);
            end else begin
                chk("data_ok_idle", sram_if.inst_sram_data_ok, 1'b0);
                chk("rdata_hold",   sram_if.inst_sram_rdata, m_last);
            end
        end
    endtask

    initial begin
        sram_if.inst_sram_wstrb = 4'h0;
        sram_if.inst_sram_wdata = 32'h0;
        axi_if.rid   = 4'd0;
        axi_if.rresp = 2'b00;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_araddr",  axi_if.araddr, 32'd0);
        chk("rst_arsize",  axi_if.arsize, 3'd0);
        chk("rst_arvalid", axi_if.arvalid, 1'b0);
        chk("rst_rready",  axi_if.rready, 1'b0);
        step();

        // single read
        drive(1'b1, 1'b0, 32'h1c000000, 1'b1, 1'b0, 32'h0); step();
        drive(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0); step();
        drive(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h02800c0c); step();
        drive(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0); step();
        step();

        // AR stall with req held, then depth limit
        drive(1'b1, 1'b0, 32'h1c000010, 1'b0, 1'b0, 32'h0); step();
        repeat (5) step();
        drive(1'b1, 1'b0, 32'h1c000014, 1'b1, 1'b0, 32'h0); step();
        step();
        repeat (4) step();
        // beat frees a slot; next cycle accept and beat together hold count
        drive(1'b1, 1'b0, 32'h1c000018, 1'b1, 1'b1, 32'h11110000); step();
        drive(1'b1, 1'b0, 32'h1c00001c, 1'b1, 1'b1, 32'h22220000); step();
        drive(1'b1, 1'b0, 32'h1c000020, 1'b1, 1'b0, 32'h0); step();
        drive(1'b1, 1'b0, 32'h1c000024, 1'b1, 1'b0, 32'h0); step();
        repeat (3) step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h33330000); step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h44440000); step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();

        // ordering, with odd rid/rresp that must be ignored
        drive(1'b1, 1'b0, 32'h1c000000, 1'b1, 1'b0, 32'h0); step();
        drive(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0); step();
        drive(1'b1, 1'b0, 32'h1c000004, 1'b1, 1'b0, 32'h0); step();
        drive(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0); step();
        axi_if.rid = 4'h5; axi_if.rresp = 2'b10;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA0000); step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB0000); step();
        axi_if.rid = 4'h0; axi_if.rresp = 2'b00;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();

        // write rejection
        drive(1'b1, 1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h0);
        repeat (10) step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();

        // reset during AR_SEND with one read outstanding
        drive(1'b1, 1'b0, 32'h1c000200, 1'b0, 1'b0, 32'h0); step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); step();
        reset = 1'b1; step();
        reset = 1'b0; step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD0000); step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); step();

        // random traffic
        for (int i = 0; i < 200; i++) begin
            axi_if.rid   = 4'($urandom_range(0, 15));
            axi_if.rresp = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)),
                  (m_out > 0) && ($urandom_range(0, 1) == 1), $urandom);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        repeat (2) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
